// File: rtl/dedekind_pkg.sv
// Shared definitions for the Dedekind-number pipeline stages.
// Holds the hypercube dimension, the vertex count derived from it, and the
// state encoding used by the component counter.
package dedekind_pkg;

   localparam int DIMS       = 7;
   localparam int GRAPH_BITS = 1 << DIMS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      EXPAND = 2'd2,
      DONE   = 2'd3
   } cc_state_e;

endpackage : dedekind_pkg

// File: rtl/component_counter_if.sv
// Handshake bundle between the singleton-elimination stage, the component
// counter and the downstream term accumulator.
//   in_valid / in_ready       : graph + singleton count transfer
//   graphIn                   : vertex-present mask (GRAPH_BITS)
//   singletonCountIn          : singletons already removed upstream (DIMS-1)
//   out_valid / out_ready     : result transfer
//   componentCount            : total component count (DIMS)
// master = producer/consumer side, slave = component counter.
interface component_counter_if;
   import dedekind_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [GRAPH_BITS-1:0] graphIn;
   logic [DIMS-2:0]       singletonCountIn;
   logic                  out_valid;
   logic                  out_ready;
   logic [DIMS-1:0]       componentCount;

   modport master (
      output in_valid, graphIn, singletonCountIn, out_ready,
      input  in_ready, out_valid, componentCount
   );

   modport slave (
      input  in_valid, graphIn, singletonCountIn, out_ready,
      output in_ready, out_valid, componentCount
   );

endinterface : component_counter_if

// File: rtl/hypercube_spread.sv
// Combinational hypercube neighbour-OR.
//   mask   : input vertex set (GRAPH_BITS)
//   spread : bit i set iff any hypercube neighbour of vertex i is in mask
// Every index below is an elaboration-time constant, so this is pure wiring
// into one DIMS-input OR per vertex.
module hypercube_spread
   import dedekind_pkg::*;
(
   input  logic [GRAPH_BITS-1:0] mask,
   output logic [GRAPH_BITS-1:0] spread
);

   for (genvar i = 0; i < GRAPH_BITS; i++) begin : g_vertex
      logic [DIMS-1:0] nbr_s;
      for (genvar v = 0; v < DIMS; v++) begin : g_dim
         assign nbr_s[v] = mask[i ^ (1 << v)];
      end
      assign spread[i] = |nbr_s;
   end

endmodule : hypercube_spread

// File: rtl/component_counter.sv
// Counts connected components of a singleton-stripped hypercube subgraph by
// repeated flood fill, then adds the upstream singleton count.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of component_counter_if (valid/ready in and out)
// Each component: one SEED cycle picks the lowest remaining vertex, then
// EXPAND grows it one hop per cycle until it stops changing.
module component_counter
   import dedekind_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   component_counter_if.slave  bus
);

   localparam logic [DIMS-1:0]       CNT_ONE = {{(DIMS-1){1'b0}}, 1'b1};
   localparam logic [GRAPH_BITS-1:0] VEC_ONE = {{(GRAPH_BITS-1){1'b0}}, 1'b1};

   cc_state_e             state_r, state_nxt_s;
   logic [GRAPH_BITS-1:0] remaining_r, remaining_nxt_s;
   logic [GRAPH_BITS-1:0] frontier_r, frontier_nxt_s;
   logic [DIMS-1:0]       count_r, count_nxt_s;
   logic                  in_ready_r, out_valid_r;

   logic [GRAPH_BITS-1:0] spread_s;
   logic [GRAPH_BITS-1:0] grown_s;
   logic [GRAPH_BITS-1:0] lowbit_s;

   hypercube_spread u_spread (
      .mask   (frontier_r),
      .spread (spread_s)
   );

   assign grown_s  = (frontier_r | spread_s) & remaining_r;
   // x & -x isolates the lowest set bit.
   assign lowbit_s = remaining_r & (~remaining_r + VEC_ONE);

   assign bus.in_ready       = in_ready_r;
   assign bus.out_valid      = out_valid_r;
   // count_r is frozen while in DONE, so it doubles as the held result.
   assign bus.componentCount = count_r;

   // Next-state and datapath update decisions.
   always_comb begin
      state_nxt_s     = state_r;
      remaining_nxt_s = remaining_r;
      frontier_nxt_s  = frontier_r;
      count_nxt_s     = count_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               remaining_nxt_s = bus.graphIn;
               count_nxt_s     = {1'b0, bus.singletonCountIn};
               state_nxt_s     = SEED;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SEED: begin
            if (remaining_r == '0) begin
               state_nxt_s = DONE;
            end else begin
               frontier_nxt_s = lowbit_s;
               state_nxt_s    = EXPAND;
            end
         end
         EXPAND: begin
            if (grown_s == frontier_r) begin
               remaining_nxt_s = remaining_r & ~frontier_r;
               count_nxt_s     = count_r + CNT_ONE;
               state_nxt_s     = SEED;
            end else begin
               frontier_nxt_s = grown_s;
               state_nxt_s    = EXPAND;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         remaining_r <= '0;
         frontier_r  <= '0;
         count_r     <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         remaining_r <= remaining_nxt_s;
         frontier_r  <= frontier_nxt_s;
         count_r     <= count_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
      end
   end

endmodule : component_counter
